// File: rtl/gap_row_serializer.sv
// Purpose: buffers wide reconstructed-row writes in a DEPTH-row FIFO and replays them one pixel per beat with a linear address.
// Latency: a row pushed into an empty FIFO is presented (idx 0) right after its push edge; one pixel per cycle after that.
// Backpressure: px_ready stalls the stream; the write side cannot stall, so a write into a full FIFO with no concurrent pop is dropped and overflow sets.
module gap_row_serializer #(
    parameter int PORT_SIZE = 32,
    parameter int PIX_W     = 16,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 4,
    localparam int IDX_W    = $clog2(PORT_SIZE),
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wen,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [PORT_SIZE*PIX_W-1:0] dout,
    output logic                       px_valid,
    input  logic                       px_ready,
    output logic [PIX_W-1:0]           px_data,
    output logic [ADDR_W+IDX_W-1:0]    px_addr,
    output logic                       px_last,
    output logic [CNT_W-1:0]           row_count,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    typedef struct packed {
        logic [ADDR_W-1:0]                 addr;
        logic [PORT_SIZE-1:0][PIX_W-1:0]   pix;
    } row_t;

    row_t             mem [DEPTH];
    row_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] idx;
    logic             xfer;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;

    assign head     = mem[rd_ptr];
    assign px_valid = (row_count != '0);
    assign px_last  = px_valid && (idx == IDX_W'(PORT_SIZE - 1));
    assign px_data  = px_valid ? head.pix[idx] : '0;
    assign px_addr  = px_valid ? {head.addr, idx} : '0;

    // Pop is folded into the full check so a full FIFO still accepts on its draining edge.
    assign xfer = px_valid && px_ready;
    assign pop  = xfer && px_last;
    assign full = (row_count == CNT_W'(DEPTH));
    assign push = wen && (!full || pop);
    assign drop = wen && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr].addr <= waddr;
            mem[wr_ptr].pix  <= dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            idx       <= '0;
            row_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                idx    <= '0;
            end else if (xfer) begin
                idx <= idx + 1'b1;
            end
            case ({push, pop})
                2'b10:   row_count <= row_count + 1'b1;
                2'b01:   row_count <= row_count - 1'b1;
                default: row_count <= row_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
